// File: rtl/reset_seq_start_ctrl.sv
// Power-on reset sequencer that releases NUM_STAGES reset domains in order,
// followed by a start/stop toggle controller fed by a synchronised trigger.
module reset_seq_start_ctrl #(
  parameter int NUM_STAGES   = 3,
  parameter int DELAY_CYCLES = 400000,
  parameter int STAGE_GAP    = 1000,
  parameter int CNT_W        = 32,
  parameter int SYNC_STAGES  = 2,
  parameter bit START_INIT   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REARM,
  input  logic                  START_TR,
  input  logic                  START_CLR,
  output logic [NUM_STAGES-1:0] RESET_ON,
  output logic                  ALL_DONE,
  output logic                  START_ON,
  output logic                  START_PULSE,
  output logic [7:0]            TRIG_COUNT
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam longint unsigned T_LAST_L =
    longint'(DELAY_CYCLES) + longint'(NUM_STAGES - 1) * longint'(STAGE_GAP);
  localparam logic [63:0] CNT_MAX_L = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] T_LAST = T_LAST_L[CNT_W-1:0];

  // Elaboration-time parameter guards.
  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
    $error("reset_seq_start_ctrl: NUM_STAGES must be 1..8");
  end
  if (DELAY_CYCLES < 1 || STAGE_GAP < 1) begin : g_bad_timing
    $error("reset_seq_start_ctrl: DELAY_CYCLES and STAGE_GAP must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_seq_start_ctrl: SYNC_STAGES must be >= 2");
  end
  if (CNT_W < 1 || CNT_W > 63) begin : g_bad_width
    $error("reset_seq_start_ctrl: CNT_W must be 1..63");
  end else if (T_LAST_L > CNT_MAX_L) begin : g_cnt_overflow
    $error("reset_seq_start_ctrl: CNT_W too narrow for last stage threshold");
  end

  // ---------------------------------------------------------------------------
  // Release counter FSM
  // ---------------------------------------------------------------------------
  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [NUM_STAGES-1:0]   stage_hit;
  logic [NUM_STAGES-1:0]   release_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: every flop has an async reset term and uses non-blocking
    // assignment so all registers update together from pre-edge values.
    if (!RESET_N) begin
      state <= HOLD;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    state_next = state;
    cnt_next   = cnt;
    if (REARM) begin
      state_next = HOLD;
      cnt_next   = '0;
    end else begin
      unique case (state)
        HOLD, COUNT: begin
          if (cnt >= T_LAST) begin
            cnt_next   = T_LAST;
            state_next = DONE;
          end else begin
            cnt_next   = cnt + 1'b1;
            state_next = (cnt_next == T_LAST) ? DONE : COUNT;
          end
        end
        DONE: begin
          cnt_next   = T_LAST;
        end
        default: begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Comparing against cnt_next makes bit k rise on exactly edge T_k.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam longint unsigned TK_L =
      longint'(DELAY_CYCLES) + longint'(k) * longint'(STAGE_GAP);
    localparam logic [CNT_W-1:0] TK = TK_L[CNT_W-1:0];
    assign stage_hit[k] = (cnt_next >= TK);
  end

  // REARM forces cnt_next to zero, and every threshold is >= 1, so the
  // release vector clears on the same edge without a separate term.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      release_q <= '0;
    end else begin
      release_q <= stage_hit;
    end
  end

  assign RESET_ON = release_q;
  assign ALL_DONE = release_q[NUM_STAGES-1];

  // ---------------------------------------------------------------------------
  // Trigger synchroniser and rising-edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tr_rise;
  logic                   accept;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else if (REARM) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], START_TR};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tr_rise = sync_q[SYNC_STAGES-1] & ~edge_q;
  // Edges seen before the last stage releases are dropped, not queued.
  assign accept  = tr_rise & ALL_DONE;

  // ---------------------------------------------------------------------------
  // Start toggle, pulse and accepted-toggle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      START_ON    <= START_INIT;
      START_PULSE <= 1'b0;
      TRIG_COUNT  <= 8'd0;
    end else if (REARM) begin
      START_ON    <= START_INIT;
      START_PULSE <= 1'b0;
    end else if (START_CLR) begin
      START_ON    <= START_INIT;
      START_PULSE <= 1'b0;
    end else if (accept) begin
      START_ON    <= ~START_ON;
      START_PULSE <= 1'b1;
      TRIG_COUNT  <= TRIG_COUNT + 8'd1;
    end else begin
      START_PULSE <= 1'b0;
    end
  end

endmodule
